arbiter_porownania: RTL and testbench

Arbiter and sequencer that shares one signed comparison datapath (`result = A > ~B`, signed) between two requesters inside the synchronous arithmetic unit. It accepts requests over a req/gnt/done handshake and picks a winner when both request at once. It latches the winner's operands, runs the comparison on a registered operand pair, and returns a one-cycle done pulse with a held result. It also counts completed operations for debug/statistics.

---
 rtl/arbiter_porownania.sv | 134 +++++++++++++
 tb/tb_arbiter_porownania.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/arbiter_porownania.sv
// Two-requester arbiter sharing one signed "A > ~B" comparator; IDLE -> EXEC -> DONE per operation.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module arbiter_porownania #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req0,
  input  logic [BITS-1:0]     i_arg_A0,
  input  logic [BITS-1:0]     i_arg_B0,
  input  logic                i_req1,
  input  logic [BITS-1:0]     i_arg_A1,
  input  logic [BITS-1:0]     i_arg_B1,
  output logic                o_gnt0,
  output logic                o_gnt1,
  output logic                o_done0,
  output logic                o_done1,
  output logic                o_result,
  output logic                o_busy,
  output logic [CNT_BITS-1:0] o_ops_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [BITS-1:0]   a_q, a_d;
  logic signed [BITS-1:0]   b_q, b_d;
  logic                     gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                     done0_q, done0_d, done1_q, done1_d;
  logic                     result_q, result_d;
  logic                     busy_q, busy_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic                     win_q, win_d;
  logic                     pick1;

`ifdef ARB_ROUND_ROBIN_EN
  logic                     last_q, last_d;

  // On a tie the requester that was not granted last time wins.
  assign pick1 = i_req1 & (~i_req0 | ~last_q);
`else
  assign pick1 = i_req1 & ~i_req0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      win_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req0 || i_req1) begin
          win_d   = pick1;
          a_d     = pick1 ? i_arg_A1 : i_arg_A0;
          b_d     = pick1 ? i_arg_B1 : i_arg_B0;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick1;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Both operands are signed, so this is a full-width signed compare.
        result_d = (a_q > ~b_q);
        done0_d  = ~win_q;
        done1_d  = win_q;
        cnt_d    = cnt_q + 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign o_gnt0    = gnt0_q;
  assign o_gnt1    = gnt1_q;
  assign o_done0   = done0_q;
  assign o_done1   = done1_q;
  assign o_result  = result_q;
  assign o_busy    = busy_q;
  assign o_ops_cnt = cnt_q;

endmodule

// File: tb/tb_arbiter_porownania.sv
// Directed bench for arbiter_porownania (BITS=8, CNT_BITS=4) with hand-computed expectations.
module tb_arbiter_porownania;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, result, busy;
  logic [3:0] ops_cnt;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_cnt;
  logic       exp_res;
  logic       exp_w;

  arbiter_porownania #(.BITS(8), .CNT_BITS(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req0   (req0),
    .i_arg_A0 (a0),
    .i_arg_B0 (b0),
    .i_req1   (req1),
    .i_arg_A1 (a1),
    .i_arg_B1 (b1),
    .o_gnt0   (gnt0),
    .o_gnt1   (gnt1),
    .o_done0  (done0),
    .o_done1  (done1),
    .o_result (result),
    .o_busy   (busy),
    .o_ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_excl();
    check("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
    check("done_excl", {31'd0, done0 & done1}, 0);
  endtask

  // One isolated operation from requester w; req dropped right after the grant.
  task automatic single_op(input logic w, input logic [7:0] a, input logic [7:0] b, input logic res);
    if (w) begin req1 = 1'b1; a1 = a; b1 = b; end
    else   begin req0 = 1'b1; a0 = a; b0 = b; end
    step();
    check("op_gnt0", {31'd0, gnt0}, {31'd0, ~w});
    check("op_gnt1", {31'd0, gnt1}, {31'd0, w});
    check("op_busy_exec", {31'd0, busy}, 1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    exp_cnt = exp_cnt + 4'd1;
    check("op_done0", {31'd0, done0}, {31'd0, ~w});
    check("op_done1", {31'd0, done1}, {31'd0, w});
    check("op_gnt_clr", {30'd0, gnt0, gnt1}, 0);
    check("op_result", {31'd0, result}, {31'd0, res});
    check("op_cnt", {28'd0, ops_cnt}, {28'd0, exp_cnt});
    check("op_busy_done", {31'd0, busy}, 1);
    step();
    check("op_done_clr", {30'd0, done0, done1}, 0);
    check("op_busy_idle", {31'd0, busy}, 0);
    check("op_result_held", {31'd0, result}, {31'd0, res});
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    exp_cnt = 4'd0;
    #2;
    check("rst_outputs", {24'd0, gnt0, gnt1, done0, done1, result, busy, 2'b00}, 0);
    check("rst_cnt", {28'd0, ops_cnt}, 0);
    step();
    rst = 1'b0;
    step();

    // 5 > ~(-3)=2
    single_op(1'b0, 8'sd5, -8'sd3, 1'b1);
    // Boundary operands through requester 1
    single_op(1'b1, 8'sd0, 8'sd0, 1'b1);
    single_op(1'b1, 8'sd0, -8'sd1, 1'b0);
    single_op(1'b1, -8'sd128, 8'sd127, 1'b0);
    single_op(1'b1, 8'sd127, -8'sd128, 1'b0);

    // Continuous dual requests; last grant so far went to requester 1
    req0 = 1'b1; a0 = 8'sd1;  b0 = 8'sd0;   // 1 > -1 -> 1
    req1 = 1'b1; a1 = -8'sd1; b1 = -8'sd1;  // -1 > 0 -> 0
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = i[0];
`else
      exp_w = 1'b0;
`endif
      step();
      check("dual_gnt0", {31'd0, gnt0}, {31'd0, ~exp_w});
      check("dual_gnt1", {31'd0, gnt1}, {31'd0, exp_w});
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      step();
      exp_cnt = exp_cnt + 4'd1;
      check("dual_done0", {31'd0, done0}, {31'd0, ~exp_w});
      check("dual_done1", {31'd0, done1}, {31'd0, exp_w});
      check("dual_result", {31'd0, result}, {31'd0, ~exp_w});
      check("dual_cnt", {28'd0, ops_cnt}, {28'd0, exp_cnt});
      step();
      check_excl();
    end

    // Reset in the middle of EXEC
    req0 = 1'b1; a0 = 8'sd5; b0 = -8'sd3;
    step();
    check("rstx_gnt0", {31'd0, gnt0}, 1);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    check("rstx_outputs", {24'd0, gnt0, gnt1, done0, done1, result, busy, 2'b00}, 0);
    check("rstx_cnt", {28'd0, ops_cnt}, 0);
    step();
    check("rstx_no_done", {30'd0, done0, done1}, 0);
    rst = 1'b0;
    exp_cnt = 4'd0;
    step();
    check("rstx_idle", {29'd0, done0, done1, busy}, 0);
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("rstx_tie_gnt0", {31'd0, gnt0}, 1);
    check("rstx_tie_gnt1", {31'd0, gnt1}, 0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    exp_cnt = exp_cnt + 4'd1;
    check("rstx_done0", {31'd0, done0}, 1);
    check("rstx_cnt1", {28'd0, ops_cnt}, {28'd0, exp_cnt});
    step();

    // 16 back-to-back ops with req0 held; counter wraps 15 -> 0
    exp_res = result;
    req0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i[0]) begin a0 = 8'sd0; b0 = -8'sd1; end  // 0 > 0 -> 0
      else      begin a0 = 8'sd1; b0 = 8'sd0;  end  // 1 > -1 -> 1
      step();
      check("b2b_gnt0", {31'd0, gnt0}, 1);
      check("b2b_held_gnt", {31'd0, result}, {31'd0, exp_res});
      check_excl();
      if (i == 15) req0 = 1'b0;
      step();
      exp_cnt = exp_cnt + 4'd1;
      exp_res = ~i[0];
      check("b2b_done0", {31'd0, done0}, 1);
      check("b2b_result", {31'd0, result}, {31'd0, exp_res});
      check("b2b_cnt", {28'd0, ops_cnt}, {28'd0, exp_cnt});
      check_excl();
      step();
      check("b2b_held_done", {31'd0, result}, {31'd0, exp_res});
      check("b2b_done_clr", {31'd0, done0}, 0);
    end
    check("b2b_wrap", {28'd0, ops_cnt}, 1);

    // req1 pulse while busy is ignored
    req0 = 1'b1; a0 = 8'sd5; b0 = -8'sd3;
    step();
    check("ign_gnt0", {31'd0, gnt0}, 1);
    req0 = 1'b0; req1 = 1'b1; a1 = 8'sd0; b1 = 8'sd0;
    step();
    req1 = 1'b0;
    check("ign_done0", {31'd0, done0}, 1);
    for (int i = 0; i < 4; i++) begin
      check("ign_gnt1", {31'd0, gnt1}, 0);
      check("ign_done1", {31'd0, done1}, 0);
      step();
    end
    check("ign_cnt", {28'd0, ops_cnt}, 2);
    check("ign_busy", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
